// File: rtl/request_arbiter_if.sv
// Core-side fetch/data request ports and the shared RAM port of the request arbiter.
// The arbiter takes the slave view; the datapath/RAM environment takes the master view.
interface request_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  localparam int LANES = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [1:0]        d_size;
  logic              d_unsigned;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              err;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [LANES-1:0]  ram_ben;
  logic              ram_wen;
  logic              ram_ren;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_busy;

  modport slave (
    input  i_req, i_addr, d_read, d_write, d_addr, d_size, d_unsigned, d_wdata,
    input  ram_rdata, ram_busy,
    output i_rdata, i_ready, d_rdata, d_ready, err,
    output ram_addr, ram_wdata, ram_ben, ram_wen, ram_ren
  );

  modport master (
    output i_req, i_addr, d_read, d_write, d_addr, d_size, d_unsigned, d_wdata,
    output ram_rdata, ram_busy,
    input  i_rdata, i_ready, d_rdata, d_ready, err,
    input  ram_addr, ram_wdata, ram_ben, ram_wen, ram_ren
  );
endinterface

// File: rtl/request_arbiter.sv
// Fetch/data arbiter onto one RAM port: ready 2 cycles after grant (+1 per busy cycle, 1 if misaligned).
// Requesters hold until ready; RAM stalls with ram_busy and is abandoned after TIMEOUT busy cycles.
module request_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              nRST,
  request_arbiter_if.slave bus
);
  localparam int LANES = DATA_W / 8;
  localparam int LB    = $clog2(LANES);
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic [DATA_W-1:0] wdata;
    logic              uns;
    logic              write;
  } req_t;

  function automatic logic [LANES-1:0] ben_of(input logic [1:0] size, input logic [LB-1:0] lane);
    case (size)
      2'b00:   ben_of = LANES'(1) << lane;
      2'b01:   ben_of = LANES'(3) << (lane & ~LB'(1));
      default: ben_of = '1;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] wdata_of(input logic [1:0] size, input logic [DATA_W-1:0] wd);
    case (size)
      2'b00:   wdata_of = {LANES{wd[7:0]}};
      2'b01:   wdata_of = {(LANES / 2){wd[15:0]}};
      default: wdata_of = wd;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_of(input req_t r, input logic [DATA_W-1:0] word);
    logic [LB-1:0]     lane;
    logic [DATA_W-1:0] sh_b;
    logic [DATA_W-1:0] sh_h;
    lane = r.addr[LB-1:0];
    sh_b = word >> {lane, 3'b000};
    sh_h = word >> {(lane & ~LB'(1)), 3'b000};
    case (r.size)
      2'b00:   load_of = r.uns ? DATA_W'(sh_b[7:0])  : DATA_W'($signed(sh_b[7:0]));
      2'b01:   load_of = r.uns ? DATA_W'(sh_h[15:0]) : DATA_W'($signed(sh_h[15:0]));
      default: load_of = word;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [LB-1:0] lane);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lane[0];
      default: misaligned = (lane != '0);
    endcase
  endfunction

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [15:0]       tcnt_q, tcnt_d;
  req_t              req_q, req_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic d_pend;
  logic gnt_sel;
  logic acc;
  logic acc_end;
  req_t d_req;
  req_t f_req;
  req_t new_req;

  assign d_pend  = bus.d_read | bus.d_write;
  // last_q = 0 means fetch was served last, so data wins a tie
  assign gnt_sel = d_pend & (~bus.i_req | ~last_q);
  assign d_req   = '{addr: bus.d_addr, size: bus.d_size, wdata: bus.d_wdata,
                     uns: bus.d_unsigned, write: bus.d_write};
  assign f_req   = '{addr: bus.i_addr & ~LANE_MASK, size: 2'b10, wdata: '0,
                     uns: 1'b0, write: 1'b0};
  assign new_req = gnt_sel ? d_req : f_req;
  assign acc     = (state_q == ACCESS);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    tcnt_d    = tcnt_q;
    req_d     = req_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    err_d     = 1'b0;
    i_rdata_d = '0;
    d_rdata_d = '0;
    acc_end   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_req || d_pend) begin
          gnt_d = gnt_sel;
          req_d = new_req;
          if (gnt_sel && misaligned(new_req.size, new_req.addr[LB-1:0])) begin
            state_d   = DONE;
            d_ready_d = 1'b1;
            err_d     = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        acc_end = !bus.ram_busy || (tcnt_q == 16'(TIMEOUT - 1));
        if (bus.ram_busy) tcnt_d = tcnt_q + 16'd1;
        if (acc_end) begin
          state_d   = DONE;
          i_ready_d = !gnt_q;
          d_ready_d = gnt_q;
          err_d     = bus.ram_busy;
          if (!bus.ram_busy) begin
            if (gnt_q) d_rdata_d = req_q.write ? '0 : load_of(req_q, bus.ram_rdata);
            else       i_rdata_d = bus.ram_rdata;
          end
        end
      end
      DONE: begin
        last_d  = gnt_q;
        tcnt_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b0;
      tcnt_q    <= '0;
      req_q     <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      tcnt_q    <= tcnt_d;
      req_q     <= req_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      err_q     <= err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // RAM strobes are a decode of the latched request, so they drop the moment ACCESS is left
  assign bus.ram_ren   = acc & ~req_q.write;
  assign bus.ram_wen   = acc & req_q.write;
  assign bus.ram_addr  = acc ? (req_q.addr & ~LANE_MASK) : '0;
  assign bus.ram_ben   = acc ? ben_of(req_q.size, req_q.addr[LB-1:0]) : '0;
  assign bus.ram_wdata = (acc && req_q.write) ? wdata_of(req_q.size, req_q.wdata) : '0;

  assign bus.i_ready = i_ready_q;
  assign bus.d_ready = d_ready_q;
  assign bus.err     = err_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
endmodule
